lbp_host: RTL
=============

LBP_HOST -- requirements
Module: lbp_host

Interface
REQ-001 Parameters: ADDR_W, 14, pixel address width (128x128 image, row-major, addr = row*128+col); PIX_W, 8, pixel/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 img_valid  input  1  load-stream pixel present.
REQ-005 img_data  input  8  load-stream pixel value, raster order from address 0.
REQ-006 img_ready  output  1  block accepts a load-stream pixel.
REQ-007 gray_ready  output  1  gray image loaded; reads are being served.
REQ-008 gray_req  input  1  read request from the LBP engine.
REQ-009 gray_addr  input  14  read address.
REQ-010 gray_data  output  8  read data, registered.
REQ-011 lbp_valid  input  1  result write strobe.
REQ-012 lbp_addr  input  14  result write address.
REQ-013 lbp_data  input  8  result write data.
REQ-014 finish  input  1  LBP engine reports completion.
REQ-015 res_valid  output  1  result-stream byte present.
REQ-016 res_data  output  8  result-stream byte, raster order from address 0.
REQ-017 res_ready  input  1  downstream accepts result byte.
REQ-018 done  output  1  full result image streamed out.
REQ-019 wr_count  output  15  number of result writes captured since reset.

Function
REQ-020 Storage: gray_mem and lbp_mem, each 16384 x 8; no reset of memory contents.
REQ-021 FSM states LOAD, SERVE, DUMP, DONE; encoding free; illegal state -> LOAD at next edge.
REQ-022 LOAD: img_ready=1; on each edge with img_valid=1, gray_mem[ld_cnt] <= img_data, ld_cnt++; acceptance of pixel 16383 -> SERVE, ld_cnt wraps to 0.
REQ-023 SERVE: gray_ready=1, img_ready=0; img_valid ignored.
REQ-024 Read: edge with state SERVE and gray_req=1 -> gray_data <= gray_mem[gray_addr] (1-cycle latency, back-to-back every cycle); otherwise gray_data holds.
REQ-025 gray_req outside SERVE: ignored, gray_data holds.
REQ-026 Write: edge with state SERVE and lbp_valid=1 -> lbp_mem[lbp_addr] <= lbp_data, wr_count++ (saturates at 32767); lbp_valid outside SERVE ignored, wr_count unchanged.
REQ-027 SERVE exits to DUMP on edge with finish=1; lbp_valid and finish in same cycle -> write captured, then DUMP.
REQ-028 Read and write same cycle: independent, both performed.
REQ-029 DUMP: res_valid=1; res_data = 0 when rd_cnt is border (row 0, row 127, col 0, col 127), else lbp_mem[rd_cnt]; res_data combinational from rd_cnt, stable while res_ready=0.
REQ-030 DUMP: edge with res_ready=1 -> rd_cnt++; acceptance at rd_cnt=16383 -> DONE.
REQ-031 DONE: done=1, res_valid=0, gray_ready=0, img_ready=0; terminal until reset.
REQ-032 gray_ready, img_ready, res_valid, done are decoded from state only (no input feed-through).

Reset
REQ-033 rst=1 -> state LOAD, ld_cnt=0, rd_cnt=0, wr_count=0, gray_data=0, gray_ready=0, res_valid=0, done=0; img_ready=1 once rst deasserted.
REQ-034 rst mid-operation (any state) -> immediate return to REQ-033 values; memory contents undefined-but-retained; full reload required.

Verification
REQ-035 Load 16384 pixels value (addr mod 256) with img_valid=1 continuous -> gray_ready=1 the cycle after pixel 16383; img_ready=0 thereafter.
REQ-036 SERVE, gray_req=1 with gray_addr=129 then 130 consecutive cycles -> gray_data=129 then 130 on the following two cycles; gray_req=0 next cycle -> gray_data holds 130.
REQ-037 lbp_valid=1, lbp_addr=200, lbp_data=0xA5, finish=1 same cycle -> wr_count=1, state DUMP; res_data at rd_cnt=200 reads 0xA5.
REQ-038 DUMP with res_ready toggling 1/0 -> rd_cnt advances only on res_ready=1; res_data=0 at addr 0,127,128,16256; done=1 after 16384th acceptance.
REQ-039 Assert rst during SERVE after 5 writes -> wr_count=0, gray_ready=0, img_ready=1 after release; lbp_valid in LOAD does not change wr_count.
REQ-040 Full flow with a reference LBP engine on random image -> streamed interior bytes match golden LBP model; wr_count=15876.

Source files
------------

// File: rtl/lbp_host_if.sv
// rtl/lbp_host_if.sv - LBP host bus bundle: image load stream, gray read, result write, result stream.
interface lbp_host_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
);
  logic              img_valid;
  logic [PIX_W-1:0]  img_data;
  logic              img_ready;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [PIX_W-1:0]  lbp_data;
  logic              finish;
  logic              res_valid;
  logic [PIX_W-1:0]  res_data;
  logic              res_ready;
  logic              done;
  logic [ADDR_W:0]   wr_count;

  modport slave (
    input  img_valid, img_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, res_ready,
    output img_ready, gray_ready, gray_data, res_valid, res_data, done, wr_count
  );

  modport master (
    output img_valid, img_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, res_ready,
    input  img_ready, gray_ready, gray_data, res_valid, res_data, done, wr_count
  );
endinterface

// File: rtl/lbp_host.sv
// rtl/lbp_host.sv - LBP host: loads a gray image, serves engine reads/writes, streams the result image.
module lbp_host #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
) (
  input logic         clk,
  input logic         rst,
  lbp_host_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int COL_W = ADDR_W / 2;
  localparam logic [ADDR_W-1:0] LAST   = '1;
  localparam logic [ADDR_W:0]   WR_MAX = '1;

  typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DUMP, S_DONE} state_t;

  logic [PIX_W-1:0] gray_mem [DEPTH];
  logic [PIX_W-1:0] lbp_mem  [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;
  logic [PIX_W-1:0]  gray_data_q, gray_data_d;
  logic              img_ready_q, img_ready_d;
  logic              gray_ready_q, gray_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wr_count_d  = wr_count_q;
    gray_data_d = gray_data_q;
    case (state_q)
      S_LOAD: begin
        if (bus.img_valid) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LAST) state_d = S_SERVE;
        end
      end
      S_SERVE: begin
        if (bus.gray_req) gray_data_d = gray_mem[bus.gray_addr];
        if (bus.lbp_valid && wr_count_q != WR_MAX) wr_count_d = wr_count_q + 1'b1;
        if (bus.finish) state_d = S_DUMP;
      end
      S_DUMP: begin
        if (bus.res_ready) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
    // Status flags are registered copies of the next-state decode.
    img_ready_d  = (state_d == S_LOAD);
    gray_ready_d = (state_d == S_SERVE);
    res_valid_d  = (state_d == S_DUMP);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LOAD;
      ld_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wr_count_q   <= '0;
      gray_data_q  <= '0;
      img_ready_q  <= 1'b1;
      gray_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_count_q   <= wr_count_d;
      gray_data_q  <= gray_data_d;
      img_ready_q  <= img_ready_d;
      gray_ready_q <= gray_ready_d;
      res_valid_q  <= res_valid_d;
      done_q       <= done_d;
    end
  end

  // Image contents survive reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && bus.img_valid) gray_mem[ld_cnt_q] <= bus.img_data;
    if (state_q == S_SERVE && bus.lbp_valid) lbp_mem[bus.lbp_addr] <= bus.lbp_data;
  end

  logic [ADDR_W-COL_W-1:0] rd_row;
  logic [COL_W-1:0]        rd_col;
  logic                    rd_border;

  assign rd_row    = rd_cnt_q[ADDR_W-1:COL_W];
  assign rd_col    = rd_cnt_q[COL_W-1:0];
  assign rd_border = (rd_row == '0) || (&rd_row) || (rd_col == '0) || (&rd_col);

  assign bus.res_data   = rd_border ? '0 : lbp_mem[rd_cnt_q];
  assign bus.img_ready  = img_ready_q;
  assign bus.gray_ready = gray_ready_q;
  assign bus.gray_data  = gray_data_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.done       = done_q;
  assign bus.wr_count   = wr_count_q;
endmodule
